// File: rtl/clock_tick_pkg.sv
// Shared constants and helpers for the clock tick generator and its channels.
// Latency: n/a (compile-time only). Backpressure: n/a.
`timescale 1ns/1ps
package clock_tick_pkg;

  localparam int NUM_CH_MAX    = 8;
  localparam int CNT_W_DEF     = 27;
  localparam int DIV_RESET_DEF = 25000;

  // Channel-select width; a single channel still needs a 1-bit port.
  function automatic int lch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/clock_tick_channel.sv
// One divider channel: counter, active/pending divisor, registered tick and square wave.
// Latency: tick one cycle after the wrap edge. Backpressure: none, free-running.
`timescale 1ns/1ps
module clock_tick_channel
  import clock_tick_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DIV_RESET = DIV_RESET_DEF
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  output logic             tick,
  output logic             sq_out
);

  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_RESET);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_act;
  logic [CNT_W-1:0] div_pend;
  logic             pend;
  logic [CNT_W-1:0] eff;
  logic             wrap;

  // A zero divisor behaves as divide-by-one.
  always_comb begin
    eff  = (div_act == '0) ? CNT_W'(1) : div_act;
    wrap = enable && (cnt == eff - CNT_W'(1));
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      cnt      <= '0;
      div_act  <= DIV_INIT;
      div_pend <= DIV_INIT;
      pend     <= 1'b0;
      tick     <= 1'b0;
    end else begin
      if (!enable || wrap) cnt <= '0;
      else                 cnt <= cnt + CNT_W'(1);
      tick <= wrap;
      // The pending flag is sampled before this edge's load, so a load
      // coinciding with a wrap waits for the following wrap.
      if (pend && (wrap || !enable)) begin
        div_act <= div_pend;
        pend    <= 1'b0;
      end
      if (load) begin
        div_pend <= load_div;
        pend     <= 1'b1;
      end
    end
  end

`ifdef CLOCK_TICK_SQUARE_OUT_EN
  always_ff @(posedge clock or posedge clear) begin
    if (clear)     sq_out <= 1'b0;
    else if (wrap) sq_out <= ~sq_out;
  end
`else
  assign sq_out = 1'b0;
`endif

endmodule

// File: rtl/clock_tick_generator.sv
// NUM_CH independent programmable tick dividers; square-wave flops only with CLOCK_TICK_SQUARE_OUT_EN.
// Latency: tick one cycle after terminal count. Backpressure: none, loads always accepted.
`timescale 1ns/1ps
module clock_tick_generator
  import clock_tick_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DIV_RESET = DIV_RESET_DEF,
  localparam int LCH_W    = lch_width(NUM_CH)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [NUM_CH-1:0] enable,
  input  logic              load,
  input  logic [LCH_W-1:0]  load_ch,
  input  logic [CNT_W-1:0]  load_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq_out
);

  // Out-of-range load_ch values match no channel and are dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ld_hit;
    assign ld_hit = load && (load_ch == LCH_W'(i));

    clock_tick_channel #(
      .CNT_W     (CNT_W),
      .DIV_RESET (DIV_RESET)
    ) u_ch (
      .clock    (clock),
      .clear    (clear),
      .enable   (enable[i]),
      .load     (ld_hit),
      .load_div (load_div),
      .tick     (tick[i]),
      .sq_out   (sq_out[i])
    );
  end

endmodule

// File: tb/tb_clock_tick_generator.sv
// Segment-table bench for clock_tick_generator with a per-cycle expectation queue.
`timescale 1ns/1ps
module tb_clock_tick_generator;

  localparam int NCH = 3;
  localparam int CW  = 8;
  localparam int DR  = 4;
`ifdef CLOCK_TICK_SQUARE_OUT_EN
  localparam bit SQ_EN = 1'b1;
`else
  localparam bit SQ_EN = 1'b0;
`endif

  logic           clock;
  logic           clear;
  logic [NCH-1:0] enable;
  logic           load;
  logic [1:0]     load_ch;
  logic [CW-1:0]  load_div;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] sq_out;

  clock_tick_generator #(
    .NUM_CH    (NCH),
    .CNT_W     (CW),
    .DIV_RESET (DR)
  ) dut (
    .clock    (clock),
    .clear    (clear),
    .enable   (enable),
    .load     (load),
    .load_ch  (load_ch),
    .load_div (load_div),
    .tick     (tick),
    .sq_out   (sq_out)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  // A segment drives its inputs for reps cycles (load only on the first);
  // tick/sq are expected on the last cycle, earlier cycles expect tick=0
  // and sq unchanged.
  typedef struct {
    logic [2:0] en;
    logic       ld;
    logic [1:0] ch;
    logic [7:0] div;
    int         reps;
    logic [2:0] tk;
    logic [2:0] sq;
  } seg_t;

  typedef struct {
    logic [2:0] tk;
    logic [2:0] sq;
    int         seg;
  } exp_t;

  seg_t       tbl[28];
  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [2:0] prev_sq;

  function automatic seg_t mk(input logic [2:0] en, input logic ld, input logic [1:0] ch,
                              input logic [7:0] div, input int reps,
                              input logic [2:0] tk, input logic [2:0] sq);
    seg_t s;
    s.en = en; s.ld = ld; s.ch = ch; s.div = div; s.reps = reps; s.tk = tk; s.sq = sq;
    return s;
  endfunction

  task automatic check3(input string name, input int idx, input logic [2:0] act, input logic [2:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s seg %0d at %0t: got %b, want %b", name, idx, $time, act, req);
    end
  endtask

  task automatic run_seg(input seg_t s, input int idx);
    exp_t e;
    exp_t got;
    for (int k = 0; k < s.reps; k++) begin
      @(negedge clock);
      enable   = s.en;
      load     = s.ld && (k == 0);
      load_ch  = s.ch;
      load_div = s.div;
      e.tk  = (k == s.reps - 1) ? s.tk : 3'b000;
      e.sq  = (k == s.reps - 1) ? s.sq : prev_sq;
      if (!SQ_EN) e.sq = 3'b000;
      e.seg = idx;
      sb.push_back(e);
      @(posedge clock);
      #1;
      got = sb.pop_front();
      check3("tick", got.seg, tick, got.tk);
      check3("sq_out", got.seg, sq_out, got.sq);
    end
    prev_sq = s.sq;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // en,   ld,  ch, div, reps, tick, sq
    tbl[0]  = mk(3'b001, 1'b0, 2'd0, 8'd0,  4,  3'b001, 3'b001); // first tick 4 after enable
    tbl[1]  = mk(3'b001, 1'b0, 2'd0, 8'd0,  4,  3'b001, 3'b000);
    tbl[2]  = mk(3'b001, 1'b0, 2'd0, 8'd0,  4,  3'b001, 3'b001);
    tbl[3]  = mk(3'b001, 1'b0, 2'd0, 8'd0,  1,  3'b000, 3'b001); // C=1
    tbl[4]  = mk(3'b001, 1'b1, 2'd0, 8'd10, 3,  3'b001, 3'b000); // load 10 mid-count, period stays 4
    tbl[5]  = mk(3'b001, 1'b0, 2'd0, 8'd0,  10, 3'b001, 3'b001);
    tbl[6]  = mk(3'b001, 1'b0, 2'd0, 8'd0,  10, 3'b001, 3'b000);
    tbl[7]  = mk(3'b001, 1'b0, 2'd0, 8'd0,  9,  3'b000, 3'b000);
    tbl[8]  = mk(3'b001, 1'b1, 2'd0, 8'd4,  1,  3'b001, 3'b001); // load on wrap edge
    tbl[9]  = mk(3'b001, 1'b0, 2'd0, 8'd0,  10, 3'b001, 3'b000); // old period once more
    tbl[10] = mk(3'b001, 1'b0, 2'd0, 8'd0,  4,  3'b001, 3'b001);
    tbl[11] = mk(3'b001, 1'b1, 2'd3, 8'd7,  4,  3'b001, 3'b000); // out-of-range channel
    tbl[12] = mk(3'b001, 1'b0, 2'd0, 8'd0,  4,  3'b001, 3'b001);
    tbl[13] = mk(3'b001, 1'b1, 2'd0, 8'd0,  4,  3'b001, 3'b000); // divisor 0
    tbl[14] = mk(3'b001, 1'b0, 2'd0, 8'd0,  1,  3'b001, 3'b001);
    tbl[15] = mk(3'b001, 1'b1, 2'd0, 8'd1,  1,  3'b001, 3'b000); // divisor 1
    tbl[16] = mk(3'b001, 1'b0, 2'd0, 8'd0,  1,  3'b001, 3'b001);
    tbl[17] = mk(3'b001, 1'b0, 2'd0, 8'd0,  1,  3'b001, 3'b000);
    tbl[18] = mk(3'b001, 1'b0, 2'd0, 8'd0,  1,  3'b001, 3'b001);
    tbl[19] = mk(3'b000, 1'b0, 2'd0, 8'd0,  3,  3'b000, 3'b001); // disabled: sq holds
    tbl[20] = mk(3'b000, 1'b1, 2'd0, 8'd3,  2,  3'b000, 3'b001); // load while disabled
    tbl[21] = mk(3'b001, 1'b0, 2'd0, 8'd0,  3,  3'b001, 3'b000);
    tbl[22] = mk(3'b001, 1'b0, 2'd0, 8'd0,  3,  3'b001, 3'b001);
    tbl[23] = mk(3'b001, 1'b0, 2'd0, 8'd0,  3,  3'b001, 3'b000);
    tbl[24] = mk(3'b001, 1'b0, 2'd0, 8'd0,  2,  3'b000, 3'b000);
    tbl[25] = mk(3'b001, 1'b1, 2'd0, 8'd9,  1,  3'b001, 3'b001); // pending 9 left at clear
    tbl[26] = mk(3'b001, 1'b0, 2'd0, 8'd0,  4,  3'b001, 3'b001); // after clear: DIV_RESET
    tbl[27] = mk(3'b001, 1'b0, 2'd0, 8'd0,  4,  3'b001, 3'b000); // pending load lost

    clear    = 1'b1;
    enable   = '0;
    load     = 1'b0;
    load_ch  = '0;
    load_div = '0;
    prev_sq  = 3'b000;

    #5;
    check3("reset_tick", -1, tick, 3'b000);
    check3("reset_sq", -1, sq_out, 3'b000);
    #2 clear = 1'b0;

    for (int i = 0; i < 26; i++) run_seg(tbl[i], i);

    // Asynchronous 3 ns clear pulse mid-period, right after a tick edge.
    load = 1'b0;
    #1 clear = 1'b1;
    #1;
    check3("clear_tick", 26, tick, 3'b000);
    check3("clear_sq", 26, sq_out, 3'b000);
    #2 clear = 1'b0;
    prev_sq = 3'b000;

    for (int i = 26; i < 28; i++) run_seg(tbl[i], i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
